// File: rtl/cond_flag_unit.sv
// NZCV flag register with ARM condition evaluation and write-strobe gating.
// Also holds a saved-flags copy for exception entry and return.
module cond_flag_unit #(
  parameter logic [3:0] RESET_FLAGS = 4'b0000,
  parameter bit         NV_EXECUTES = 1'b0
) (
  input  logic       CLK,
  input  logic       RESETn,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] FlagW,
  input  logic       PCS,
  input  logic       RegW,
  input  logic       MemW,
  input  logic       NoWrite,
  input  logic       Stall,
  input  logic       SaveFlags,
  input  logic       RestoreFlags,
  output logic       CondEx,
  output logic       PCSrc,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic [3:0] Flags,
  output logic [3:0] SavedFlags,
  output logic       CarryIn
);

  logic [3:0] flags_q, flags_d;
  logic [3:0] saved_q, saved_d;
  logic       n, z, c, v;

  assign n = flags_q[3];
  assign z = flags_q[2];
  assign c = flags_q[1];
  assign v = flags_q[0];

  // Conditions look only at the registered flags; there is no ALUFlags bypass.
  always_comb begin
    CondEx = 1'b0;
    unique case (Cond)
      4'b0000: CondEx = z;
      4'b0001: CondEx = ~z;
      4'b0010: CondEx = c;
      4'b0011: CondEx = ~c;
      4'b0100: CondEx = n;
      4'b0101: CondEx = ~n;
      4'b0110: CondEx = v;
      4'b0111: CondEx = ~v;
      4'b1000: CondEx = c & ~z;
      4'b1001: CondEx = ~c | z;
      4'b1010: CondEx = (n == v);
      4'b1011: CondEx = (n != v);
      4'b1100: CondEx = ~z & (n == v);
      4'b1101: CondEx = z | (n != v);
      4'b1110: CondEx = 1'b1;
      4'b1111: CondEx = NV_EXECUTES;
      default: CondEx = 1'b0;
    endcase
  end

  assign PCSrc    = ~Stall & PCS & CondEx;
  assign RegWrite = ~Stall & RegW & CondEx & ~NoWrite;
  assign MemWrite = ~Stall & MemW & CondEx;

  // Restore outranks stall; simultaneous save and restore swaps the two copies.
  always_comb begin
    flags_d = flags_q;
    saved_d = saved_q;
    if (RestoreFlags) begin
      flags_d = saved_q;
    end else if (!Stall && CondEx) begin
      if (FlagW[1]) flags_d[3:2] = ALUFlags[3:2];
      if (FlagW[0]) flags_d[1:0] = ALUFlags[1:0];
    end
    if (SaveFlags) saved_d = flags_q;
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      flags_q <= RESET_FLAGS;
      saved_q <= RESET_FLAGS;
    end else begin
      flags_q <= flags_d;
      saved_q <= saved_d;
    end
  end

  assign Flags      = flags_q;
  assign SavedFlags = saved_q;
  assign CarryIn    = flags_q[1];

endmodule
